// File: rtl/mem_pkg.sv
// Shared encodings and request-decode helpers for the byte-serial memory access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    DT_BYTE = 2'b00,
    DT_HALF = 2'b01,
    DT_WORD = 2'b10,
    DT_RSVD = 2'b11
  } dt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    ACK  = 2'd3
  } state_e;

  function automatic logic [2:0] dt_bytes(input logic [1:0] dt);
    case (dt)
      DT_BYTE: return 3'd1;
      DT_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Reserved size or a base address not aligned to the access size.
  function automatic logic req_bad(input logic [1:0] dt, input logic [1:0] lsb);
    case (dt)
      DT_BYTE: return 1'b0;
      DT_HALF: return lsb[0];
      DT_WORD: return |lsb;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Sign/zero extension of the assembled read word according to access size.
module mem_extend
  import mem_pkg::*;
(
  input  logic        [1:0]  dt,
  input  logic               sign,
  input  logic        [31:0] word,
  output logic        [31:0] ext
);

  logic signed [31:0] byte_s;
  logic signed [31:0] half_s;

  always_comb begin
    byte_s = {{24{sign & word[7]}}, word[7:0]};
    half_s = {{16{sign & word[15]}}, word[15:0]};
    case (dt)
      DT_BYTE: ext = byte_s;
      DT_HALF: ext = half_s;
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial, big-endian access controller between the CPU MOV/MOC handshake and a
// byte-wide synchronous RAM port.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mov,
  input  logic              r_w,
  input  logic [1:0]        dt,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              moc,
  output logic              busy,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_e            state;
  logic [1:0]        cnt;
  logic              r_w_q;
  logic [1:0]        dt_q;
  logic              sign_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        last_q;
  logic [23:0]       wsh;
  logic [23:0]       rsh;
  logic [DATA_W-1:0] wr_aligned;
  logic [DATA_W-1:0] rd_ext;

  // Left-justify write data so the first (most significant) byte sits at [31:24].
  always_comb begin
    case (dt)
      DT_BYTE: wr_aligned = data_in << 24;
      DT_HALF: wr_aligned = data_in << 16;
      default: wr_aligned = data_in;
    endcase
  end

  mem_extend u_extend (
    .dt   (dt_q),
    .sign (sign_q),
    .word ({rsh, ram_rdata}),
    .ext  (rd_ext)
  );

  // Request latch and byte shift registers
  always_ff @(posedge clk) begin
    if (state == IDLE && mov) begin
      r_w_q  <= r_w;
      dt_q   <= dt;
      sign_q <= sign;
      base_q <= addr;
      last_q <= 2'(dt_bytes(dt) - 3'd1);
      wsh    <= wr_aligned[23:0];
    end else if (state == XFER) begin
      wsh <= wsh << 8;
      if (cnt != 2'd0)
        rsh <= {rsh[15:0], ram_rdata};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      data_out  <= '0;
      moc       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (mov) begin
            busy <= 1'b1;
            if (req_bad(dt, addr[1:0])) begin
              state <= ACK;
              moc   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= XFER;
              cnt       <= 2'd0;
              ram_en    <= 1'b1;
              ram_we    <= ~r_w;
              ram_addr  <= addr;
              ram_wdata <= wr_aligned[31:24];
            end
          end
        end
        XFER: begin
          if (cnt == last_q) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'h00;
            if (r_w_q) begin
              state <= CAPT;
            end else begin
              state <= ACK;
              moc   <= 1'b1;
            end
          end else begin
            cnt       <= cnt + 2'd1;
            ram_addr  <= base_q + ADDR_W'(cnt) + ADDR_W'(1);
            ram_wdata <= wsh[23:16];
          end
        end
        CAPT: begin
          data_out <= rd_ext;
          moc      <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          if (!mov) begin
            state <= IDLE;
            cnt   <= 2'd0;
            moc   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a byte-array RAM and a
// behavioural reference memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mov = 1'b0;
  logic        r_w = 1'b0;
  logic [1:0]  dt = 2'b00;
  logic        sign = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        moc, busy, err, ram_en, ram_we;
  logic [7:0]  ram_addr, ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] exp_dout = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .clr(clr), .mov(mov), .r_w(r_w), .dt(dt), .sign(sign),
    .addr(addr), .data_in(data_in), .data_out(data_out), .moc(moc),
    .busy(busy), .err(err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous 256x8 RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  function automatic int nbytes(input logic [1:0] d);
    return (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_bad(input logic [1:0] d, input logic [7:0] a);
    return (d == 2'b11) || (d == 2'b01 && (a % 2) != 0) || (d == 2'b10 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] d, input bit s, input logic [7:0] a);
    longint v = 0;
    int n = nbytes(d);
    for (int i = 0; i < n; i++) v = v * 256 + ref_mem[int'(a) + i];
    if (d != 2'b10 && s && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_write(input logic [1:0] d, input logic [7:0] a, input logic [31:0] wd);
    int n = nbytes(d);
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  function automatic logic [31:0] exp_addr_seq(input logic [1:0] d, input logic [7:0] a);
    logic [31:0] s = 0;
    for (int i = 0; i < nbytes(d); i++) s = {s[23:0], 8'(int'(a) + i)};
    return s;
  endfunction

  // Drive one request, record what the DUT did cycle by cycle, then release mov.
  task automatic run_req(input bit rw, input logic [1:0] d, input bit s, input logic [7:0] a,
                         input logic [31:0] wd, input int hold,
                         output int moc_cyc, output logic [31:0] en_mask, output logic [31:0] we_mask,
                         output logic [31:0] addr_seq, output logic err_o, output logic [31:0] dout,
                         output int moc_held, output logic moc_after, output logic busy_after,
                         output logic err_after);
    @(negedge clk);
    mov = 1'b1; r_w = rw; dt = d; sign = s; addr = a; data_in = wd;
    moc_cyc = -1; en_mask = 0; we_mask = 0; addr_seq = 0; err_o = 1'b0; dout = 0; moc_held = 0;
    for (int c = 1; c <= 20 && moc_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        r_w = 1'($urandom); dt = 2'($urandom); sign = 1'($urandom);
        addr = 8'($urandom); data_in = $urandom;
      end
      if (ram_en) begin
        en_mask[c] = 1'b1;
        addr_seq = {addr_seq[23:0], ram_addr};
      end
      if (ram_we) we_mask[c] = 1'b1;
      if (moc) begin
        moc_cyc = c; err_o = err; dout = data_out;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (moc) moc_held++;
      if (ram_en) en_mask[31] = 1'b1;
    end
    mov = 1'b0;
    @(negedge clk);
    moc_after = moc; busy_after = busy; err_after = err;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({data_out, moc, busy, err, ram_en, ram_we, ram_addr, ram_wdata} !== 53'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got dout=%h moc=%b busy=%b err=%b en=%b we=%b a=%h wd=%h, expected all 0",
               data_out, moc, busy, err, ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_fill();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    logic [31:0] wd;
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      run_req(1'b0, 2'b10, 1'b0, 8'(w * 4), wd, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
      model_write(2'b10, 8'(w * 4), wd);
      vectors++;
      if (mc !== 5) begin
        miscompares++;
        $display("FAIL fill_moc_cycle: addr=%h got %0d expected 5", w * 4, mc);
      end
    end
    vectors++;
    if (mem_diffs() != 0) begin
      miscompares++;
      $display("FAIL fill_memory: %0d bytes differ, expected 0", mem_diffs());
    end
  endtask

  task automatic test_word_rw();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    run_req(1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    model_write(2'b10, 8'h10, 32'hDEADBEEF);
    vectors++;
    if (mc !== 5) begin miscompares++; $display("FAIL word_write_moc: got %0d expected 5", mc); end
    vectors++;
    if (wm !== 32'h1E) begin miscompares++; $display("FAIL word_write_we_cycles: got %h expected 0000001e", wm); end
    vectors++;
    if (as !== 32'h10111213) begin miscompares++; $display("FAIL word_write_addrs: got %h expected 10111213", as); end
    vectors++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_write_ram: got %h%h%h%h expected deadbeef", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    run_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    exp_dout = 32'hDEADBEEF;
    vectors++;
    if (mc !== 6) begin miscompares++; $display("FAIL word_read_moc: got %0d expected 6", mc); end
    vectors++;
    if (dv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_read_data: got %h expected deadbeef", dv); end
    vectors++;
    if (wm !== 32'h0 || em !== 32'h1E) begin
      miscompares++;
      $display("FAIL word_read_strobes: got en=%h we=%h expected en=0000001e we=0", em, wm);
    end
  endtask

  task automatic test_byte_read();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    run_req(1'b0, 2'b00, 1'b0, 8'h21, 32'hFFFF_FF80, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    model_write(2'b00, 8'h21, 32'h80);
    vectors++;
    if (mc !== 2) begin miscompares++; $display("FAIL byte_write_moc: got %0d expected 2", mc); end
    run_req(1'b1, 2'b00, 1'b1, 8'h21, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    vectors++;
    if (mc !== 3 || dv !== 32'hFFFFFF80) begin
      miscompares++;
      $display("FAIL byte_read_signed: got cyc=%0d data=%h expected cyc=3 data=ffffff80", mc, dv);
    end
    run_req(1'b1, 2'b00, 1'b0, 8'h21, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    exp_dout = 32'h80;
    vectors++;
    if (mc !== 3 || dv !== 32'h00000080) begin
      miscompares++;
      $display("FAIL byte_read_unsigned: got cyc=%0d data=%h expected cyc=3 data=00000080", mc, dv);
    end
  endtask

  task automatic test_half_read();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    run_req(1'b0, 2'b01, 1'b0, 8'h40, 32'h5555_9ABC, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    model_write(2'b01, 8'h40, 32'h9ABC);
    vectors++;
    if (mc !== 3 || {mem[8'h40], mem[8'h41]} !== 16'h9ABC) begin
      miscompares++;
      $display("FAIL half_write: got cyc=%0d ram=%h%h expected cyc=3 ram=9abc", mc, mem[8'h40], mem[8'h41]);
    end
    run_req(1'b1, 2'b01, 1'b1, 8'h40, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    exp_dout = 32'hFFFF9ABC;
    vectors++;
    if (mc !== 4 || dv !== 32'hFFFF9ABC) begin
      miscompares++;
      $display("FAIL half_read_signed: got cyc=%0d data=%h expected cyc=4 data=ffff9abc", mc, dv);
    end
  endtask

  task automatic test_errors();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    run_req(1'b1, 2'b10, 1'b0, 8'h42, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    vectors++;
    if (mc !== 1 || eo !== 1'b1 || em !== 32'h0 || dv !== exp_dout) begin
      miscompares++;
      $display("FAIL misaligned_word: got cyc=%0d err=%b en=%h data=%h expected cyc=1 err=1 en=0 data=%h",
               mc, eo, em, dv, exp_dout);
    end
    vectors++;
    if (ma !== 1'b0 || ea !== 1'b0 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_release: got moc=%b err=%b busy=%b expected 0 0 0", ma, ea, ba);
    end
    run_req(1'b0, 2'b11, 1'b0, 8'h00, 32'h12345678, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    vectors++;
    if (mc !== 1 || eo !== 1'b1 || em !== 32'h0 || dv !== exp_dout || mem_diffs() != 0) begin
      miscompares++;
      $display("FAIL reserved_dt: got cyc=%0d err=%b en=%h data=%h ramdiff=%0d expected cyc=1 err=1 en=0 data=%h ramdiff=0",
               mc, eo, em, dv, mem_diffs(), exp_dout);
    end
  endtask

  task automatic test_handshake();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    run_req(1'b0, 2'b00, 1'b0, 8'h33, 32'hA5, 5, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    model_write(2'b00, 8'h33, 32'hA5);
    vectors++;
    if (mh !== 5 || em[31] !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_mov: got moc_cycles=%0d extra_access=%b expected 5 and 0", mh, em[31]);
    end
    vectors++;
    if (ma !== 1'b0 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got moc=%b busy=%b expected 0 0", ma, ba);
    end
  endtask

  task automatic test_clr_abort();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    logic [7:0] old81, old82, old83;
    old81 = ref_mem[8'h81]; old82 = ref_mem[8'h82]; old83 = ref_mem[8'h83];
    @(negedge clk);
    mov = 1'b1; r_w = 1'b0; dt = 2'b10; sign = 1'b0; addr = 8'h80; data_in = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    mov = 1'b0;
    #1;
    vectors++;
    if ({data_out, moc, busy, err, ram_en, ram_we, ram_addr, ram_wdata} !== 53'h0) begin
      miscompares++;
      $display("FAIL clr_outputs: got dout=%h moc=%b busy=%b err=%b en=%b we=%b a=%h wd=%h expected all 0",
               data_out, moc, busy, err, ram_en, ram_we, ram_addr, ram_wdata);
    end
    #1 clr = 1'b0;
    exp_dout = 32'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if (moc !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_no_moc: got moc=%b busy=%b expected 0 0", moc, busy);
    end
    vectors++;
    if (mem[8'h80] !== 8'h11 || mem[8'h82] !== old82 || mem[8'h83] !== old83 ||
        (mem[8'h81] !== old81 && mem[8'h81] !== 8'h22)) begin
      miscompares++;
      $display("FAIL clr_ram: got %h %h %h %h expected 11 (%h|22) %h %h",
               mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83], old81, old82, old83);
    end
    ref_mem[8'h80] = 8'h11;
    ref_mem[8'h81] = mem[8'h81];
    run_req(1'b1, 2'b10, 1'b0, 8'h80, 32'h0, 0, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
    exp_dout = model_read(2'b10, 1'b0, 8'h80);
    vectors++;
    if (mc !== 6 || dv !== exp_dout) begin
      miscompares++;
      $display("FAIL clr_next_request: got cyc=%0d data=%h expected cyc=6 data=%h", mc, dv, exp_dout);
    end
  endtask

  task automatic test_random();
    int mc; logic [31:0] em, wm, as, dv; logic eo, ma, ba, ea; int mh;
    bit rw, s, bad; logic [1:0] d; logic [7:0] a; logic [31:0] wd;
    int n, exp_cyc, hold;
    for (int k = 0; k < 120; k++) begin
      rw = 1'($urandom); s = 1'($urandom); d = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      a = 8'($urandom); wd = $urandom; hold = $urandom_range(0, 2);
      n = nbytes(d);
      if ($urandom_range(0, 3) != 0) a = 8'(int'(a) / n * n);
      bad = is_bad(d, a);
      run_req(rw, d, s, a, wd, hold, mc, em, wm, as, eo, dv, mh, ma, ba, ea);
      exp_cyc = bad ? 1 : (rw ? n + 2 : n + 1);
      if (!bad && rw) exp_dout = model_read(d, s, a);
      if (!bad && !rw) model_write(d, a, wd);
      vectors++;
      if (mc !== exp_cyc || eo !== bad || dv !== exp_dout) begin
        miscompares++;
        $display("FAIL rand_req rw=%b dt=%0d s=%b a=%h: got cyc=%0d err=%b data=%h expected cyc=%0d err=%b data=%h",
                 rw, d, s, a, mc, eo, dv, exp_cyc, bad, exp_dout);
      end
      vectors++;
      if (em !== (bad ? 32'h0 : 32'(((1 << n) - 1) << 1)) ||
          wm !== ((bad || rw) ? 32'h0 : 32'(((1 << n) - 1) << 1)) ||
          as !== (bad ? 32'h0 : exp_addr_seq(d, a)) || mh !== hold) begin
        miscompares++;
        $display("FAIL rand_ram_port rw=%b dt=%0d a=%h: got en=%h we=%h addrs=%h held=%0d", rw, d, a, em, wm, as, mh);
      end
      vectors++;
      if (ma !== 1'b0 || ba !== 1'b0 || ea !== 1'b0 || mem_diffs() != 0) begin
        miscompares++;
        $display("FAIL rand_after: got moc=%b busy=%b err=%b ramdiff=%0d expected 0 0 0 0", ma, ba, ea, mem_diffs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_rw();
    test_byte_read();
    test_half_read();
    test_errors();
    test_handshake();
    test_clr_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
